// File: rtl/radix2_divider.sv
// Multicycle restoring divider for MIPS32 DIV/DIVU. It produces one quotient bit
// per cycle and folds the sign correction into the final result write.
module radix2_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic        OP_div,
  input  logic        OP_divu,
  input  logic [31:0] Dividend,
  input  logic [31:0] Divisor,
  output logic [31:0] Quotient,
  output logic [31:0] Remainder,
  output logic        Stall
);

  // state | meaning
  // IDLE  | waiting for OP_div/OP_divu; last result held on Quotient/Remainder
  // BUSY  | iterating, one quotient bit per cycle; Stall high
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q;
  logic [31:0] p_q;
  logic [31:0] q_q;
  logic [31:0] dvsr_q;
  logic        neg_quo_q, neg_rem_q;

  logic        start, signed_op, last;
  logic [31:0] dvd_mag, dvs_mag;
  logic [32:0] trial;
  logic [31:0] p_next, q_next;

  always_comb begin
    start     = OP_div | OP_divu;
    signed_op = OP_div;
    dvd_mag   = (signed_op && Dividend[31]) ? (~Dividend + 32'd1) : Dividend;
    dvs_mag   = (signed_op && Divisor[31])  ? (~Divisor + 32'd1)  : Divisor;
    last      = (count_q == 5'd0);
    // The partial remainder always stays below the divisor, so 32 bits of P are
    // enough; the borrow out of the 33-bit trial subtract selects restore/keep.
    trial     = {p_q, q_q[31]} - {1'b0, dvsr_q};
    p_next    = {p_q[30:0], q_q[31]};
    q_next    = {q_q[30:0], 1'b0};
    if (!trial[32]) begin
      p_next = trial[31:0];
      q_next = {q_q[30:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: if (last)  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= 5'd0;
      p_q       <= 32'd0;
      q_q       <= 32'd0;
      dvsr_q    <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      Quotient  <= 32'd0;
      Remainder <= 32'd0;
      Stall     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            p_q       <= 32'd0;
            q_q       <= dvd_mag;
            dvsr_q    <= dvs_mag;
            neg_quo_q <= signed_op & (Dividend[31] ^ Divisor[31]);
            neg_rem_q <= signed_op & Dividend[31];
            count_q   <= 5'd31;
            Stall     <= 1'b1;
          end
        end
        BUSY: begin
          p_q     <= p_next;
          q_q     <= q_next;
          count_q <= count_q - 5'd1;
          if (last) begin
            Quotient  <= neg_quo_q ? (~q_next + 32'd1) : q_next;
            Remainder <= neg_rem_q ? (~p_next + 32'd1) : p_next;
            Stall     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
